// File: rtl/if_exec_controller.sv
// rtl/if_exec_controller.sv - fetch/pipeline sequencer with program loader and halt drain
module if_exec_controller #(
  parameter int         IMEM_AW     = 8,
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int         DRAIN_CYC   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CMD_LOAD,
  input  logic               CMD_RUN,
  input  logic               CMD_STEP,
  input  logic               CMD_STOP,
  input  logic               LOAD_VALID,
  input  logic [31:0]        LOAD_DATA,
  input  logic               LOAD_LAST,
  output logic               LOAD_READY,
  input  logic [31:0]        INSTR_IN,
  output logic               IMEM_WE,
  output logic [IMEM_AW-1:0] IMEM_WADDR,
  output logic [31:0]        IMEM_WDATA,
  output logic               PIPE_EN,
  output logic               IF_SEL,
  output logic [31:0]        IF_PC_EXT,
  output logic [2:0]         STATE,
  output logic               HALTED,
  output logic [31:0]        CYCLE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PCINIT = 3'd2,
    S_READY  = 3'd3,
    S_RUN    = 3'd4,
    S_STEP   = 3'd5,
    S_DRAIN  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam int                 DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [IMEM_AW-1:0] WADDR_MAX  = '1;

  state_t             state;
  state_t             next_state;
  logic [DW-1:0]      drain_cnt;
  logic [IMEM_AW-1:0] waddr;
  logic               halt_hit;
  logic               next_pipe_en;
  logic               unused_instr_bits;

  // Only the opcode field of the fetched instruction matters here.
  assign unused_instr_bits = ^INSTR_IN[25:0];

  // The loader owns the write port only while in LOAD; data passes straight through.
  assign LOAD_READY = (state == S_LOAD);
  assign IMEM_WE    = LOAD_VALID & LOAD_READY;
  assign IMEM_WDATA = LOAD_DATA;
  assign IMEM_WADDR = waddr;
  assign IF_PC_EXT  = '0;
  assign STATE      = state;

  // RUN and STEP always have PIPE_EN high, so the state alone qualifies the halt check.
  assign halt_hit = ((state == S_RUN) || (state == S_STEP)) &&
                    (INSTR_IN[31:26] == HALT_OPCODE);

  assign next_pipe_en = (next_state == S_PCINIT) || (next_state == S_RUN) ||
                        (next_state == S_STEP)   || (next_state == S_DRAIN);

  // Next-state selection; command priority LOAD > STOP > STEP > RUN, illegal commands dropped.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (CMD_LOAD) next_state = S_LOAD;
      S_LOAD:   if (IMEM_WE && (LOAD_LAST || (waddr == WADDR_MAX))) next_state = S_PCINIT;
      S_PCINIT: next_state = S_READY;
      S_READY: begin
        if (CMD_LOAD)      next_state = S_LOAD;
        else if (CMD_STEP) next_state = S_STEP;
        else if (CMD_RUN)  next_state = S_RUN;
      end
      S_RUN: begin
        if (halt_hit)      next_state = S_DRAIN;
        else if (CMD_STOP) next_state = S_READY;
      end
      S_STEP:   next_state = halt_hit ? S_DRAIN : S_READY;
      S_DRAIN:  if (drain_cnt == DRAIN_LAST) next_state = S_HALT;
      S_HALT:   if (CMD_LOAD) next_state = S_LOAD;
      default:  next_state = S_IDLE;
    endcase
  end

  // State, registered outputs and counters; outputs are decoded from the next state so they align with STATE.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      waddr     <= '0;
      drain_cnt <= '0;
      CYCLE_CNT <= '0;
      PIPE_EN   <= 1'b0;
      IF_SEL    <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state   <= next_state;
      PIPE_EN <= next_pipe_en;
      IF_SEL  <= (next_state == S_PCINIT);
      HALTED  <= (next_state == S_HALT);
      if ((next_state == S_LOAD) && (state != S_LOAD)) begin
        waddr     <= '0;
        drain_cnt <= '0;
        CYCLE_CNT <= '0;
      end else begin
        if (IMEM_WE && (waddr != WADDR_MAX)) waddr <= waddr + 1'b1;
        if (PIPE_EN && (state != S_PCINIT) && (CYCLE_CNT != 32'hFFFF_FFFF))
          CYCLE_CNT <= CYCLE_CNT + 32'd1;
        if ((state == S_DRAIN) && (drain_cnt != DRAIN_LAST)) drain_cnt <= drain_cnt + 1'b1;
        else drain_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_exec_controller.sv
// tb/tb_if_exec_controller.sv - scoreboard bench for if_exec_controller
module tb_if_exec_controller;

  logic        CLK;
  logic        RESET;
  logic        CMD_LOAD, CMD_RUN, CMD_STEP, CMD_STOP;
  logic        LOAD_VALID, LOAD_LAST;
  logic [31:0] LOAD_DATA;
  logic [31:0] INSTR_IN;

  logic        LOAD_READY, IMEM_WE, PIPE_EN, IF_SEL, HALTED;
  logic [7:0]  IMEM_WADDR;
  logic [31:0] IMEM_WDATA, IF_PC_EXT, CYCLE_CNT;
  logic [2:0]  STATE;

  logic        cmd_load_s, load_valid_s;
  logic [31:0] load_data_s;
  logic        load_ready_s, imem_we_s, pipe_en_s, if_sel_s, halted_s;
  logic [1:0]  imem_waddr_s;
  logic [31:0] imem_wdata_s, if_pc_ext_s, cycle_cnt_s;
  logic [2:0]  state_s;

  int passed = 0;
  int total  = 0;

  logic [39:0] exp_q[$];
  logic [39:0] exp_s_q[$];
  logic [39:0] e_big;
  logic [39:0] e_small;

  if_exec_controller #(.IMEM_AW(8), .HALT_OPCODE(6'h3F), .DRAIN_CYC(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_LOAD(CMD_LOAD), .CMD_RUN(CMD_RUN), .CMD_STEP(CMD_STEP), .CMD_STOP(CMD_STOP),
    .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .LOAD_LAST(LOAD_LAST),
    .LOAD_READY(LOAD_READY), .INSTR_IN(INSTR_IN),
    .IMEM_WE(IMEM_WE), .IMEM_WADDR(IMEM_WADDR), .IMEM_WDATA(IMEM_WDATA),
    .PIPE_EN(PIPE_EN), .IF_SEL(IF_SEL), .IF_PC_EXT(IF_PC_EXT),
    .STATE(STATE), .HALTED(HALTED), .CYCLE_CNT(CYCLE_CNT)
  );

  if_exec_controller #(.IMEM_AW(2), .HALT_OPCODE(6'h3F), .DRAIN_CYC(4)) dut_s (
    .CLK(CLK), .RESET(RESET),
    .CMD_LOAD(cmd_load_s), .CMD_RUN(CMD_RUN), .CMD_STEP(CMD_STEP), .CMD_STOP(CMD_STOP),
    .LOAD_VALID(load_valid_s), .LOAD_DATA(load_data_s), .LOAD_LAST(LOAD_LAST),
    .LOAD_READY(load_ready_s), .INSTR_IN(INSTR_IN),
    .IMEM_WE(imem_we_s), .IMEM_WADDR(imem_waddr_s), .IMEM_WDATA(imem_wdata_s),
    .PIPE_EN(pipe_en_s), .IF_SEL(if_sel_s), .IF_PC_EXT(if_pc_ext_s),
    .STATE(state_s), .HALTED(halted_s), .CYCLE_CNT(cycle_cnt_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Write monitor for the 256-word instance.
  always @(negedge CLK) begin
    if (IMEM_WE) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected addr=%0d data=0x%08h", IMEM_WADDR, IMEM_WDATA);
      end else begin
        e_big = exp_q.pop_front();
        check("wr_addr", 32'(IMEM_WADDR), 32'(e_big[39:32]));
        check("wr_data", IMEM_WDATA, e_big[31:0]);
      end
    end
  end

  // Write monitor for the 4-word instance.
  always @(negedge CLK) begin
    if (imem_we_s) begin
      if (exp_s_q.size() == 0) begin
        total++;
        $display("FAIL s_wr_unexpected addr=%0d data=0x%08h", imem_waddr_s, imem_wdata_s);
      end else begin
        e_small = exp_s_q.pop_front();
        check("s_wr_addr", 32'(imem_waddr_s), 32'(e_small[39:32]));
        check("s_wr_data", imem_wdata_s, e_small[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA  = base + 32'(i);
      LOAD_LAST  = (i == n - 1);
      exp_q.push_back({8'(i), base + 32'(i)});
      tick();
    end
    LOAD_VALID = 1'b0;
    LOAD_LAST  = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    CMD_LOAD = 0; CMD_RUN = 0; CMD_STEP = 0; CMD_STOP = 0;
    LOAD_VALID = 0; LOAD_LAST = 0; LOAD_DATA = '0; INSTR_IN = '0;
    cmd_load_s = 0; load_valid_s = 0; load_data_s = '0;
    tick(); tick(); tick();
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_pipe_en", 32'(PIPE_EN), 32'd0);
    check("rst_load_ready", 32'(LOAD_READY), 32'd0);
    RESET = 1'b1;
    tick();

    // Three-word load, LAST on the third word.
    CMD_LOAD = 1; tick(); CMD_LOAD = 0;
    check("load_state", 32'(STATE), 32'd1);
    check("load_ready", 32'(LOAD_READY), 32'd1);
    load_words(3, 32'hA000_0010);
    check("pcinit_state", 32'(STATE), 32'd2);
    check("pcinit_sel", 32'(IF_SEL), 32'd1);
    check("pcinit_pc_ext", IF_PC_EXT, 32'd0);
    check("pcinit_pipe_en", 32'(PIPE_EN), 32'd1);
    tick();
    check("ready_state", 32'(STATE), 32'd3);
    check("ready_pipe_en", 32'(PIPE_EN), 32'd0);
    check("ready_sel", 32'(IF_SEL), 32'd0);
    check("ready_cnt", CYCLE_CNT, 32'd0);

    // Three single steps.
    for (int k = 0; k < 3; k++) begin
      CMD_STEP = 1; tick(); CMD_STEP = 0;
      check("step_state", 32'(STATE), 32'd5);
      check("step_pipe_en", 32'(PIPE_EN), 32'd1);
      tick();
      check("step_ret_state", 32'(STATE), 32'd3);
      check("step_ret_pipe_en", 32'(PIPE_EN), 32'd0);
      check("step_cnt", CYCLE_CNT, 32'(k + 1));
    end

    // Reload from READY clears the counter, then run into a halt opcode at run cycle 10.
    CMD_LOAD = 1; tick(); CMD_LOAD = 0;
    check("reload_state", 32'(STATE), 32'd1);
    check("reload_cnt", CYCLE_CNT, 32'd0);
    check("reload_waddr", 32'(IMEM_WADDR), 32'd0);
    load_words(1, 32'hB000_0000);
    tick();
    check("ready2_state", 32'(STATE), 32'd3);
    CMD_RUN = 1; tick(); CMD_RUN = 0;
    for (int c = 1; c < 10; c++) begin
      check("run_pipe_en", 32'(PIPE_EN), 32'd1);
      tick();
    end
    check("run10_state", 32'(STATE), 32'd4);
    INSTR_IN = 32'hFC00_0000;
    CMD_STOP = 1;
    tick();
    INSTR_IN = 32'h0000_0000;
    CMD_STOP = 0;
    check("drain_state", 32'(STATE), 32'd6);
    check("drain_entry_cnt", CYCLE_CNT, 32'd10);
    for (int d = 0; d < 4; d++) begin
      check("drain_pipe_en", 32'(PIPE_EN), 32'd1);
      CMD_STOP = (d == 1);
      tick();
    end
    CMD_STOP = 0;
    check("halt_state", 32'(STATE), 32'd7);
    check("halt_pipe_en", 32'(PIPE_EN), 32'd0);
    check("halt_halted", 32'(HALTED), 32'd1);
    check("halt_cnt", CYCLE_CNT, 32'd14);

    // RUN in HALT ignored, LOAD in HALT restarts.
    CMD_RUN = 1; tick(); CMD_RUN = 0;
    check("halt_run_ignored", 32'(STATE), 32'd7);
    CMD_LOAD = 1; tick(); CMD_LOAD = 0;
    check("halt_load_state", 32'(STATE), 32'd1);
    check("halt_load_cnt", CYCLE_CNT, 32'd0);
    check("halt_load_halted", 32'(HALTED), 32'd0);
    load_words(2, 32'hC000_0100);
    tick();
    CMD_RUN = 1; tick(); CMD_RUN = 0;
    tick();
    CMD_STOP = 1; CMD_STEP = 1; tick(); CMD_STOP = 0; CMD_STEP = 0;
    check("stop_step_state", 32'(STATE), 32'd3);
    check("stop_step_pipe_en", 32'(PIPE_EN), 32'd0);
    check("stop_step_cnt", CYCLE_CNT, 32'd2);
    tick();
    check("stop_step_hold", 32'(STATE), 32'd3);

    // Four-word memory, six words offered with no LAST.
    cmd_load_s = 1; tick(); cmd_load_s = 0;
    for (int i = 0; i < 6; i++) begin
      check("s_load_ready", 32'(load_ready_s), 32'(i < 4));
      load_valid_s = 1'b1;
      load_data_s  = 32'hD000_0000 + 32'(i);
      if (i < 4) exp_s_q.push_back({8'(i), 32'hD000_0000 + 32'(i)});
      tick();
      if (i == 3) check("s_pcinit_state", 32'(state_s), 32'd2);
    end
    load_valid_s = 1'b0;
    check("s_ready_state", 32'(state_s), 32'd3);
    check("s_waddr_nowrap", 32'(imem_waddr_s), 32'd3);

    // Reset in the middle of a run.
    CMD_RUN = 1; tick(); CMD_RUN = 0;
    tick(); tick();
    check("prerst_state", 32'(STATE), 32'd4);
    RESET = 1'b0;
    tick();
    check("midrst_state", 32'(STATE), 32'd0);
    check("midrst_pipe_en", 32'(PIPE_EN), 32'd0);
    check("midrst_cnt", CYCLE_CNT, 32'd0);
    check("midrst_we", 32'(IMEM_WE), 32'd0);
    tick(); tick();
    check("rst3_state", 32'(STATE), 32'd0);
    check("rst3_cnt", CYCLE_CNT, 32'd0);
    RESET = 1'b1;
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("sb_s_empty", 32'(exp_s_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
